interp_block_sequencer: RTL and testbench

Control sequencer for the 8x8 HEVC sub-pixel interpolation datapath. It replaces the free-running counter and comparator decode with an explicit handshaked state machine. Per block it does three things:
- Accepts the 15 reference rows (8 output + 7 filter-tap margin) from upstream.
- Drives the input shift-register load, the row-mux select and the horizontal half-pel shift enables.
- Sequences the 8 vertical filter passes and tags each output row.

It sits between the reference-row fetch and the input_array_mux / FIR_A/B/C / shift_reg datapath.

---
 rtl/interp_seq_pkg.sv | 21 ++
 rtl/seq_delay_line.sv | 45 ++++
 rtl/interp_block_sequencer.sv | 125 ++++++++++++
 tb/tb_interp_block_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/interp_seq_pkg.sv
// rtl/interp_seq_pkg.sv - shared constants and state type for the interpolation block sequencer
package interp_seq_pkg;

  localparam int BLK         = 8;
  localparam int TAPS        = 8;
  localparam int ROWS_IN     = BLK + TAPS - 1;
  localparam int FIR_LAT_DEF = 2;

  localparam int RCNT_W = 4;
  localparam int VSEL_W = 3;
  localparam int DCNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_VERT,
    S_DRAIN,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/seq_delay_line.sv
// rtl/seq_delay_line.sv - LAT-deep {valid, tag} register chain matching the FIR pipeline latency
module seq_delay_line
  import interp_seq_pkg::*;
#(
  parameter int LAT = FIR_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [VSEL_W-1:0] in_tag_i,
  output logic              out_valid_o,
  output logic [VSEL_W-1:0] out_tag_o,
  output logic              pend_o
);

  logic [LAT-1:0]    valid_q;
  logic [VSEL_W-1:0] tag_q [LAT];

  // Tags are zeroed when not valid so an idle chain presents all-zero outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid_i;
      tag_q[0]   <= in_valid_i ? in_tag_i : '0;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[LAT-1];
  assign out_tag_o   = tag_q[LAT-1];

  generate
    if (LAT > 1) begin : g_pend
      assign pend_o = |valid_q[LAT-2:0];
    end else begin : g_nopend
      assign pend_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/interp_block_sequencer.sv
// rtl/interp_block_sequencer.sv - handshaked fill/vertical/drain sequencer for the 8x8 interpolation datapath
module interp_block_sequencer #(
  parameter int BLK     = interp_seq_pkg::BLK,
  parameter int TAPS    = interp_seq_pkg::TAPS,
  parameter int FIR_LAT = interp_seq_pkg::FIR_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       row_valid,
  output logic       row_ready,
  output logic       load_in,
  output logic       phase,
  output logic [2:0] vsel,
  output logic       shift_h,
  output logic       out_valid,
  output logic [2:0] out_row,
  output logic       busy,
  output logic       done
);

  import interp_seq_pkg::*;

  localparam logic [RCNT_W-1:0] ROWS_IN_C  = RCNT_W'(BLK + TAPS - 1);
  localparam logic [VSEL_W-1:0] VSEL_LAST  = VSEL_W'(BLK - 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(FIR_LAT - 1);

  seq_state_e        state_q;
  logic [RCNT_W-1:0] rcnt_q;
  logic [VSEL_W-1:0] vsel_q;
  logic [DCNT_W-1:0] dcnt_q;
  logic              phase_q;
  logic              busy_q;
  logic              done_q;

  logic              h_valid;
  logic              h_pend;
  logic [VSEL_W-1:0] h_tag_unused;
  logic              v_pend_unused;

  assign row_ready = (state_q == S_FILL) && (rcnt_q < ROWS_IN_C);
  assign load_in   = row_valid && row_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rcnt_q  <= '0;
      vsel_q  <= '0;
      dcnt_q  <= '0;
      phase_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FILL;
            rcnt_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_FILL: begin
          if (load_in) rcnt_q <= rcnt_q + RCNT_W'(1);
          // Leave only once the last loaded row has come out of the horizontal FIR.
          if ((rcnt_q == ROWS_IN_C) && h_valid && !h_pend) begin
            state_q <= S_VERT;
            phase_q <= 1'b1;
            vsel_q  <= '0;
          end
        end
        S_VERT: begin
          if (vsel_q == VSEL_LAST) begin
            state_q <= S_DRAIN;
            dcnt_q  <= '0;
          end else begin
            vsel_q <= vsel_q + VSEL_W'(1);
          end
        end
        S_DRAIN: begin
          if (dcnt_q == DRAIN_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            phase_q <= 1'b0;
            vsel_q  <= '0;
          end else begin
            dcnt_q <= dcnt_q + DCNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  seq_delay_line #(.LAT(FIR_LAT)) u_hchain (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (load_in),
    .in_tag_i   ('0),
    .out_valid_o(h_valid),
    .out_tag_o  (h_tag_unused),
    .pend_o     (h_pend)
  );

  seq_delay_line #(.LAT(FIR_LAT)) u_vchain (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (state_q == S_VERT),
    .in_tag_i   (vsel_q),
    .out_valid_o(out_valid),
    .out_tag_o  (out_row),
    .pend_o     (v_pend_unused)
  );

  assign shift_h = h_valid;
  assign phase   = phase_q;
  assign vsel    = vsel_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_interp_block_sequencer.sv
// tb/tb_interp_block_sequencer.sv - scoreboard bench for interp_block_sequencer at FIR_LAT 2 and 1
module tb_interp_block_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst, start, row_valid;
  logic       row_ready, load_in, phase, shift_h, out_valid, busy, done;
  logic [2:0] vsel, out_row;

  logic       rst1, start1, row_valid1;
  logic       row_ready1, load_in1, phase1, shift_h1, out_valid1, busy1, done1;
  logic [2:0] vsel1, out_row1;

  interp_block_sequencer #(.BLK(8), .TAPS(8), .FIR_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .row_valid(row_valid),
    .row_ready(row_ready), .load_in(load_in), .phase(phase), .vsel(vsel),
    .shift_h(shift_h), .out_valid(out_valid), .out_row(out_row),
    .busy(busy), .done(done)
  );

  interp_block_sequencer #(.BLK(8), .TAPS(8), .FIR_LAT(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .row_valid(row_valid1),
    .row_ready(row_ready1), .load_in(load_in1), .phase(phase1), .vsel(vsel1),
    .shift_h(shift_h1), .out_valid(out_valid1), .out_row(out_row1),
    .busy(busy1), .done(done1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {int c; int r;} ev_t;
  ev_t out_q[$];
  int  done_q[$];
  ev_t out1_q[$];
  int  done1_q[$];
  ev_t e0, e1;
  int  d0, d1;

  int loads, shifts, first_shift, last_shift;
  logic [2:0] vsel1_prev = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int zero_vec();
    return int'({row_ready, load_in, phase, vsel, shift_h, out_valid, out_row, busy, done});
  endfunction

  always @(negedge clk) begin
    if (load_in === 1'b1) loads++;
    if (shift_h === 1'b1) begin
      if (shifts == 0) first_shift = cyc;
      last_shift = cyc;
      shifts++;
    end
    if (out_valid === 1'b1) begin
      if (out_q.size() == 0) chk("out_valid_unexpected", 1, 0);
      else begin
        e0 = out_q.pop_front();
        chk("out_valid_cycle", cyc, e0.c);
        chk("out_row", int'(out_row), e0.r);
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        d0 = done_q.pop_front();
        chk("done_cycle", cyc, d0);
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid1 === 1'b1) begin
      chk("lat1_trail_vsel", int'(out_row1), int'(vsel1_prev));
      if (out1_q.size() == 0) chk("lat1_out_unexpected", 1, 0);
      else begin
        e1 = out1_q.pop_front();
        chk("lat1_out_cycle", cyc, e1.c);
        chk("lat1_out_row", int'(out_row1), e1.r);
      end
    end
    if (done1 === 1'b1) begin
      if (done1_q.size() == 0) chk("lat1_done_unexpected", 1, 0);
      else begin
        d1 = done1_q.pop_front();
        chk("lat1_done_cycle", cyc, d1);
      end
    end
    vsel1_prev = vsel1;
  end

  task automatic run_block(input int g, input int abort_at, input bit pulses);
    int k;
    ev_t ev;
    loads  = 0;
    shifts = 0;
    start     = 1'b1;
    row_valid = 1'b1;
    k = cyc;
    for (int r = 0; r < 8; r++) begin
      ev.c = k + 20 + r + g;
      ev.r = r;
      if (abort_at == 0 || ev.c <= k + abort_at) out_q.push_back(ev);
    end
    if (abort_at == 0) done_q.push_back(k + 28 + g);
    @(posedge clk); #1;
    for (int i = 1; i <= 35 + g; i++) begin
      row_valid = !(g > 0 && i >= 7 && i <= 6 + g);
      start     = pulses && (i == 5 || i == 20);
      if (abort_at > 0 && i == abort_at) rst = 1'b1;
      if (abort_at > 0 && i == abort_at + 1) begin
        rst = 1'b0;
        start = 1'b0;
        row_valid = 1'b0;
        @(negedge clk);
        chk("abort_outputs_zero", zero_vec(), 0);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    start     = 1'b0;
    row_valid = 1'b0;
    @(negedge clk);
    chk("load_count", loads, 15);
    chk("shift_count", shifts, 15);
    chk("first_shift", first_shift, k + 3);
    chk("last_shift", last_shift, k + 17 + g);
    chk("out_pending", out_q.size(), 0);
    chk("done_pending", done_q.size(), 0);
    chk("busy_after", int'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_block_lat1();
    int k;
    ev_t ev;
    start1     = 1'b1;
    row_valid1 = 1'b1;
    k = cyc;
    for (int r = 0; r < 8; r++) begin
      ev.c = k + 18 + r;
      ev.r = r;
      out1_q.push_back(ev);
    end
    done1_q.push_back(k + 26);
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
    end
    row_valid1 = 1'b0;
    @(negedge clk);
    chk("lat1_out_pending", out1_q.size(), 0);
    chk("lat1_done_pending", done1_q.size(), 0);
    chk("lat1_busy_after", int'(busy1), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; row_valid = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; row_valid1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rst1 = 1'b0;
    row_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_outputs_zero", zero_vec(), 0);
    end
    @(posedge clk); #1;
    row_valid = 1'b0;

    run_block(0, 0, 1'b0);
    run_block(4, 0, 1'b0);
    run_block(0, 0, 1'b1);
    run_block(0, 20, 1'b0);
    run_block(0, 0, 1'b0);
    run_block_lat1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
